// File: rtl/multicycle_controller_if.sv
// Control bus between the multicycle ARM datapath and its controller.
//   Instr      : IR bits [31:12] {Cond, Op, Funct, Rn, Rd}, driven by the datapath
//   ALUFlags   : live {N,Z,C,V} from the ALU, driven by the datapath
//   PCWrite, AdrSrc, MemWrite, IRWrite, ResultSrc, ALUSrcA, ALUSrcB,
//   ImmSrc, RegSrc, RegWrite, ALUControl, Shift : controller outputs
// master = datapath side, slave = controller side.
interface multicycle_controller_if;
  logic [19:0] Instr;
  logic [3:0]  ALUFlags;
  logic        PCWrite;
  logic        AdrSrc;
  logic        MemWrite;
  logic        IRWrite;
  logic [1:0]  ResultSrc;
  logic        ALUSrcA;
  logic [1:0]  ALUSrcB;
  logic [1:0]  ImmSrc;
  logic [1:0]  RegSrc;
  logic        RegWrite;
  logic [2:0]  ALUControl;
  logic        Shift;

  modport master (
    output Instr, ALUFlags,
    input  PCWrite, AdrSrc, MemWrite, IRWrite, ResultSrc, ALUSrcA, ALUSrcB,
           ImmSrc, RegSrc, RegWrite, ALUControl, Shift
  );

  modport slave (
    input  Instr, ALUFlags,
    output PCWrite, AdrSrc, MemWrite, IRWrite, ResultSrc, ALUSrcA, ALUSrcB,
           ImmSrc, RegSrc, RegWrite, ALUControl, Shift
  );
endinterface

// File: rtl/multicycle_controller.sv
// Moore control FSM sequencing a multicycle ARM datapath (shared instruction/
// data memory, IR/Data/A/WriteData/ALUOut registers). Owns the NZCV flags and
// conditional-execution logic.
//   clk   : clock, all state updates on posedge
//   reset : asynchronous active-low reset (0 = reset)
//   bus   : controller side of multicycle_controller_if (Instr/ALUFlags in,
//           every datapath select and write enable out)
module multicycle_controller #(
  parameter logic [3:0] RD_PC = 4'hF
) (
  input  logic                         clk,
  input  logic                         reset,
  multicycle_controller_if.slave       bus
);

  localparam int unsigned STATE_W = 4;
  localparam int unsigned FLAGS_W = 4;

  typedef enum logic [STATE_W-1:0] {
    S_FETCH  = 4'd0,
    S_DECODE = 4'd1,
    S_MEMADR = 4'd2,
    S_MEMRD  = 4'd3,
    S_MEMWB  = 4'd4,
    S_MEMWR  = 4'd5,
    S_EXECR  = 4'd6,
    S_EXECI  = 4'd7,
    S_ALUWB  = 4'd8,
    S_BRANCH = 4'd9
  } state_e;

  state_e               state_q, state_d;
  logic [FLAGS_W-1:0]   flags_q, flags_d;       // {N,Z,C,V}
  logic                 cond_ex_dly_q, cond_ex_dly_d;

  // Instruction fields
  logic [3:0] cond;
  logic [1:0] op;
  logic [5:0] funct;
  logic [3:0] rd;
  logic       unused_rn;

  assign cond      = bus.Instr[19:16];
  assign op        = bus.Instr[15:14];
  assign funct     = bus.Instr[13:8];
  assign rd        = bus.Instr[3:0];
  assign unused_rn = ^bus.Instr[7:4];

  // Per-state control terms (ungated)
  logic       fetch_st;
  logic       irw;
  logic       adr_src;
  logic       mem_w;
  logic       reg_w;
  logic       branch;
  logic       alu_op;
  logic       exec_st;
  logic [1:0] result_src;
  logic       alu_src_a;
  logic [1:0] alu_src_b;

  // ALU function decode
  logic       alu_valid;
  logic       add_sub;
  logic       shift_dec;
  logic [2:0] alu_dec;
  logic [1:0] flag_w;

  logic       cond_ex;
  logic       pcs;

  // State and flag registers
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q       <= S_FETCH;
      flags_q       <= '0;
      cond_ex_dly_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      flags_q       <= flags_d;
      cond_ex_dly_q <= cond_ex_dly_d;
    end
  end

  // Next state and per-state control terms
  always_comb begin
    state_d    = S_FETCH;
    fetch_st   = 1'b0;
    irw        = 1'b0;
    adr_src    = 1'b0;
    mem_w      = 1'b0;
    reg_w      = 1'b0;
    branch     = 1'b0;
    alu_op     = 1'b0;
    exec_st    = 1'b0;
    result_src = 2'b00;
    alu_src_a  = 1'b0;
    alu_src_b  = 2'b00;
    case (state_q)
      S_FETCH: begin
        state_d    = S_DECODE;
        fetch_st   = 1'b1;
        irw        = 1'b1;
        alu_src_a  = 1'b1;
        alu_src_b  = 2'b10;
        result_src = 2'b10;
      end
      S_DECODE: begin
        // PC+4 again so an R15 read sees PC+8
        alu_src_a  = 1'b1;
        alu_src_b  = 2'b10;
        result_src = 2'b10;
        case (op)
          2'b00:   state_d = funct[5] ? S_EXECI : S_EXECR;
          2'b01:   state_d = S_MEMADR;
          2'b10:   state_d = S_BRANCH;
          default: state_d = S_FETCH;
        endcase
      end
      S_MEMADR: begin
        alu_src_b = 2'b01;
        state_d   = funct[0] ? S_MEMRD : S_MEMWR;
      end
      S_MEMRD: begin
        adr_src = 1'b1;
        state_d = S_MEMWB;
      end
      S_MEMWB: begin
        result_src = 2'b01;
        reg_w      = 1'b1;
        state_d    = S_FETCH;
      end
      S_MEMWR: begin
        adr_src = 1'b1;
        mem_w   = 1'b1;
        state_d = S_FETCH;
      end
      S_EXECR: begin
        alu_op  = 1'b1;
        exec_st = 1'b1;
        state_d = S_ALUWB;
      end
      S_EXECI: begin
        alu_src_b = 2'b01;
        alu_op    = 1'b1;
        exec_st   = 1'b1;
        state_d   = S_ALUWB;
      end
      S_ALUWB: begin
        // Unsupported ALU codes retire as a NOP
        reg_w   = alu_valid;
        state_d = S_FETCH;
      end
      S_BRANCH: begin
        alu_src_b  = 2'b01;
        result_src = 2'b10;
        branch     = 1'b1;
        state_d    = S_FETCH;
      end
      default: state_d = S_FETCH;
    endcase
  end

  // ALU function decode from Funct[4:1]
  always_comb begin
    alu_valid = 1'b1;
    add_sub   = 1'b0;
    shift_dec = 1'b0;
    alu_dec   = 3'b000;
    case (funct[4:1])
      4'b0100: begin alu_dec = 3'b000; add_sub = 1'b1; end
      4'b0010: begin alu_dec = 3'b001; add_sub = 1'b1; end
      4'b0000: alu_dec = 3'b010;
      4'b1100: alu_dec = 3'b011;
      4'b0001: alu_dec = 3'b100;
      4'b1101: begin alu_dec = 3'b101; shift_dec = 1'b1; end
      default: alu_valid = 1'b0;
    endcase
    flag_w = {funct[0] & alu_valid, funct[0] & alu_valid & add_sub};
  end

  // Condition check against the registered flags
  always_comb begin
    cond_ex = 1'b0;
    case (cond)
      4'b0000: cond_ex = flags_q[2];
      4'b0001: cond_ex = ~flags_q[2];
      4'b0010: cond_ex = flags_q[1];
      4'b0011: cond_ex = ~flags_q[1];
      4'b0100: cond_ex = flags_q[3];
      4'b0101: cond_ex = ~flags_q[3];
      4'b0110: cond_ex = flags_q[0];
      4'b0111: cond_ex = ~flags_q[0];
      4'b1000: cond_ex = flags_q[1] & ~flags_q[2];
      4'b1001: cond_ex = ~flags_q[1] | flags_q[2];
      4'b1010: cond_ex = (flags_q[3] == flags_q[0]);
      4'b1011: cond_ex = (flags_q[3] != flags_q[0]);
      4'b1100: cond_ex = ~flags_q[2] & (flags_q[3] == flags_q[0]);
      4'b1101: cond_ex = flags_q[2] | (flags_q[3] != flags_q[0]);
      4'b1110: cond_ex = 1'b1;
      default: cond_ex = 1'b0;
    endcase
  end

  // Flags load only at the end of an execute step; write-back uses the
  // delayed condition so it never sees its own flag update.
  always_comb begin
    flags_d       = flags_q;
    cond_ex_dly_d = cond_ex;
    if (exec_st && cond_ex) begin
      if (flag_w[1]) flags_d[3:2] = bus.ALUFlags[3:2];
      if (flag_w[0]) flags_d[1:0] = bus.ALUFlags[1:0];
    end
  end

  assign pcs = branch | (reg_w & (rd == RD_PC));

  // Enables are forced low combinationally while reset is held
  assign bus.PCWrite    = reset & (fetch_st | (pcs & cond_ex_dly_q));
  assign bus.IRWrite    = reset & irw;
  assign bus.RegWrite   = reset & reg_w & cond_ex_dly_q;
  assign bus.MemWrite   = reset & mem_w & cond_ex_dly_q;
  assign bus.AdrSrc     = adr_src;
  assign bus.ResultSrc  = result_src;
  assign bus.ALUSrcA    = alu_src_a;
  assign bus.ALUSrcB    = alu_src_b;
  assign bus.ALUControl = alu_op ? alu_dec : 3'b000;
  assign bus.Shift      = alu_op & shift_dec;

  // Immediate and register-source selects follow Op in every state
  always_comb begin
    bus.ImmSrc = 2'b00;
    bus.RegSrc = 2'b00;
    case (op)
      2'b01:   begin bus.ImmSrc = 2'b01; bus.RegSrc = 2'b10; end
      2'b10:   begin bus.ImmSrc = 2'b10; bus.RegSrc = 2'b01; end
      default: begin bus.ImmSrc = 2'b00; bus.RegSrc = 2'b00; end
    endcase
  end

endmodule

// File: tb/tb_multicycle_controller.sv
// Self-checking bench for multicycle_controller: a directed instruction table
// with hand-derived per-cycle enable masks, a mid-store reset sequence, and
// random instructions checked against an instruction-level reference model.
module tb_multicycle_controller;

  logic clk = 1'b0;
  logic reset;
  int   checks = 0;
  int   errors = 0;
  logic [3:0] mflags;   // model {N,Z,C,V}

  multicycle_controller_if bus ();

  multicycle_controller #(.RD_PC(4'hF)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [19:0] instr;
    logic [3:0]  ef;      // ALUFlags presented in the execute cycle
    int          ncyc;
    logic [4:0]  regw_m;  // bit i = expected value in cycle i
    logic [4:0]  memw_m;
    logic [4:0]  pcw_m;
    logic [4:0]  adr_m;
    logic [2:0]  alc;     // ALUControl in cycle 2
    logic        sh;      // Shift in cycle 2
  } vec_t;

  localparam int NV = 19;
  vec_t tbl [NV];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [17:0] outv();
    return {bus.PCWrite, bus.AdrSrc, bus.MemWrite, bus.IRWrite, bus.ResultSrc,
            bus.ALUSrcA, bus.ALUSrcB, bus.ImmSrc, bus.RegSrc, bus.RegWrite,
            bus.ALUControl, bus.Shift};
  endfunction

  function automatic logic [17:0] mkv(input logic pcw, input logic adr, input logic memw,
                                      input logic irw, input logic [1:0] rs, input logic asa,
                                      input logic [1:0] asb, input logic [1:0] op,
                                      input logic regw, input logic [2:0] alc, input logic sh);
    logic [1:0] imm;
    logic [1:0] rsrc;
    imm  = 2'b00;
    rsrc = 2'b00;
    if (op == 2'b01) begin imm = 2'b01; rsrc = 2'b10; end
    if (op == 2'b10) begin imm = 2'b10; rsrc = 2'b01; end
    return {pcw, adr, memw, irw, rs, asa, asb, imm, rsrc, regw, alc, sh};
  endfunction

  // ARM condition: evaluate the even code of each pair, odd code inverts it
  function automatic logic cond_pass(input logic [3:0] c, input logic [3:0] f);
    logic r;
    logic n, z, cf, v;
    {n, z, cf, v} = f;
    case (c[3:1])
      3'd0: r = z;
      3'd1: r = cf;
      3'd2: r = n;
      3'd3: r = v;
      3'd4: r = cf & ~z;
      3'd5: r = (n == v);
      3'd6: r = ~z & (n == v);
      default: r = 1'b1;
    endcase
    if (c == 4'hF) return 1'b0;
    return c[0] ? ~r : r;
  endfunction

  // {valid, add_or_sub, ALUControl}
  function automatic logic [4:0] alu_ref(input logic [3:0] code);
    case (code)
      4'b0100: return 5'b11_000;
      4'b0010: return 5'b11_001;
      4'b0000: return 5'b10_010;
      4'b1100: return 5'b10_011;
      4'b0001: return 5'b10_100;
      4'b1101: return 5'b10_101;
      default: return 5'b00_000;
    endcase
  endfunction

  function automatic int n_cycles(input logic [19:0] ins);
    case (ins[15:14])
      2'b00:   return 4;
      2'b01:   return ins[8] ? 5 : 4;
      2'b10:   return 3;
      default: return 2;
    endcase
  endfunction

  // Expected control word for cycle i of an instruction whose condition is 'pass'
  function automatic logic [17:0] exp_cycle(input logic [19:0] ins, input int i, input logic pass);
    logic [1:0] op;
    logic [5:0] f;
    logic       rd15;
    logic [4:0] a;
    op   = ins[15:14];
    f    = ins[13:8];
    rd15 = (ins[3:0] == 4'hF);
    a    = alu_ref(f[4:1]);
    if (i == 0) return mkv(1, 0, 0, 1, 2'b10, 1, 2'b10, op, 0, 3'b000, 0);
    if (i == 1) return mkv(0, 0, 0, 0, 2'b10, 1, 2'b10, op, 0, 3'b000, 0);
    if (op == 2'b00) begin
      if (i == 2) return mkv(0, 0, 0, 0, 2'b00, 0, f[5] ? 2'b01 : 2'b00, op, 0,
                             a[2:0], a[4] && (a[2:0] == 3'b101));
      return mkv(a[4] & pass & rd15, 0, 0, 0, 2'b00, 0, 2'b00, op, a[4] & pass, 3'b000, 0);
    end
    if (op == 2'b01) begin
      if (i == 2) return mkv(0, 0, 0, 0, 2'b00, 0, 2'b01, op, 0, 3'b000, 0);
      if (f[0]) begin
        if (i == 3) return mkv(0, 1, 0, 0, 2'b00, 0, 2'b00, op, 0, 3'b000, 0);
        return mkv(pass & rd15, 0, 0, 0, 2'b01, 0, 2'b00, op, pass, 3'b000, 0);
      end
      return mkv(0, 1, pass, 0, 2'b00, 0, 2'b00, op, 0, 3'b000, 0);
    end
    return mkv(pass, 0, 0, 0, 2'b10, 0, 2'b01, op, 0, 3'b000, 0);
  endfunction

  // Entered at posedge+1 of the instruction's fetch cycle; leaves at the next one
  task automatic run_model(input logic [19:0] ins, input string tag);
    logic       pass;
    logic [3:0] ef;
    logic [4:0] a;
    pass = cond_pass(ins[19:16], mflags);
    ef   = 4'($urandom);
    a    = alu_ref(ins[12:9]);
    for (int i = 0; i < n_cycles(ins); i++) begin
      bus.Instr    = ins;
      bus.ALUFlags = (i == 2) ? ef : 4'($urandom);
      @(negedge clk);
      chk($sformatf("%s %05h cyc%0d ctrl", tag, ins, i), 32'(outv()), 32'(exp_cycle(ins, i, pass)));
      @(posedge clk); #1;
    end
    if (ins[15:14] == 2'b00 && a[4] && pass && ins[8]) begin
      mflags[3:2] = ef[3:2];
      if (a[3]) mflags[1:0] = ef[1:0];
    end
  endtask

  initial begin
    tbl[0]  = '{20'hE2802, 4'h0, 4, 5'b01000, 5'b0, 5'b00001, 5'b0,     3'b000, 1'b0}; // ADD
    tbl[1]  = '{20'hE0513, 4'h6, 4, 5'b01000, 5'b0, 5'b00001, 5'b0,     3'b001, 1'b0}; // SUBS -> Z,C
    tbl[2]  = '{20'h02802, 4'h0, 4, 5'b01000, 5'b0, 5'b00001, 5'b0,     3'b000, 1'b0}; // ADDEQ
    tbl[3]  = '{20'h0280F, 4'h0, 4, 5'b01000, 5'b0, 5'b01001, 5'b0,     3'b000, 1'b0}; // ADDEQ PC
    tbl[4]  = '{20'h1280F, 4'h0, 4, 5'b00000, 5'b0, 5'b00001, 5'b0,     3'b000, 1'b0}; // ADDNE PC
    tbl[5]  = '{20'hE5901, 4'h0, 5, 5'b10000, 5'b0, 5'b00001, 5'b01000, 3'b000, 1'b0}; // LDR
    tbl[6]  = '{20'hE5801, 4'h0, 4, 5'b00000, 5'b01000, 5'b00001, 5'b01000, 3'b000, 1'b0}; // STR
    tbl[7]  = '{20'hEA000, 4'h0, 3, 5'b00000, 5'b0, 5'b00101, 5'b0,     3'b000, 1'b0}; // B
    tbl[8]  = '{20'h0A000, 4'h0, 3, 5'b00000, 5'b0, 5'b00101, 5'b0,     3'b000, 1'b0}; // BEQ, Z=1
    tbl[9]  = '{20'h1A000, 4'h0, 3, 5'b00000, 5'b0, 5'b00001, 5'b0,     3'b000, 1'b0}; // BNE, Z=1
    tbl[10] = '{20'hE0113, 4'h0, 4, 5'b01000, 5'b0, 5'b00001, 5'b0,     3'b010, 1'b0}; // ANDS -> Z=0, C kept
    tbl[11] = '{20'h0A000, 4'h0, 3, 5'b00000, 5'b0, 5'b00001, 5'b0,     3'b000, 1'b0}; // BEQ, Z=0
    tbl[12] = '{20'h2A000, 4'h0, 3, 5'b00000, 5'b0, 5'b00101, 5'b0,     3'b000, 1'b0}; // BCS, C=1
    tbl[13] = '{20'hE1A04, 4'h0, 4, 5'b01000, 5'b0, 5'b00001, 5'b0,     3'b101, 1'b1}; // MOV LSL
    tbl[14] = '{20'hE0214, 4'h0, 4, 5'b01000, 5'b0, 5'b00001, 5'b0,     3'b100, 1'b0}; // EOR
    tbl[15] = '{20'hEC000, 4'h0, 2, 5'b00000, 5'b0, 5'b00001, 5'b0,     3'b000, 1'b0}; // Op=11
    tbl[16] = '{20'hE1E04, 4'h0, 4, 5'b00000, 5'b0, 5'b00001, 5'b0,     3'b000, 1'b0}; // bad ALU code
    tbl[17] = '{20'hE1804, 4'h0, 4, 5'b01000, 5'b0, 5'b00001, 5'b0,     3'b011, 1'b0}; // ORR
    tbl[18] = '{20'hE591F, 4'h0, 5, 5'b10000, 5'b0, 5'b10001, 5'b01000, 3'b000, 1'b0}; // LDR PC

    reset        = 1'b0;
    bus.Instr    = '0;
    bus.ALUFlags = '0;
    mflags       = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("reset outputs", 32'(outv()), 32'(mkv(0, 0, 0, 0, 2'b10, 1, 2'b10, 2'b00, 0, 3'b000, 0)));
    @(posedge clk); #1;
    reset = 1'b1;

    // Directed table
    for (int k = 0; k < NV; k++) begin
      for (int i = 0; i < tbl[k].ncyc; i++) begin
        bus.Instr    = tbl[k].instr;
        bus.ALUFlags = (i == 2) ? tbl[k].ef : 4'($urandom);
        @(negedge clk);
        chk($sformatf("v%0d c%0d RegWrite", k, i), 32'(bus.RegWrite), 32'(tbl[k].regw_m[i]));
        chk($sformatf("v%0d c%0d MemWrite", k, i), 32'(bus.MemWrite), 32'(tbl[k].memw_m[i]));
        chk($sformatf("v%0d c%0d PCWrite", k, i),  32'(bus.PCWrite),  32'(tbl[k].pcw_m[i]));
        chk($sformatf("v%0d c%0d AdrSrc", k, i),   32'(bus.AdrSrc),   32'(tbl[k].adr_m[i]));
        chk($sformatf("v%0d c%0d IRWrite", k, i),  32'(bus.IRWrite),  32'(i == 0));
        if (i == 2) begin
          chk($sformatf("v%0d ALUControl", k), 32'(bus.ALUControl), 32'(tbl[k].alc));
          chk($sformatf("v%0d Shift", k),      32'(bus.Shift),      32'(tbl[k].sh));
        end
        @(posedge clk); #1;
      end
    end

    // Reset asserted during the write cycle of a store (C=1 beforehand)
    for (int i = 0; i < 4; i++) begin
      bus.Instr    = 20'hE5801;
      bus.ALUFlags = 4'($urandom);
      @(negedge clk);
      if (i < 3) begin
        @(posedge clk); #1;
      end
    end
    chk("STR MemWrite before reset", 32'(bus.MemWrite), 32'd1);
    #1 reset = 1'b0;
    #1;
    chk("STR MemWrite in reset", 32'(bus.MemWrite), 32'd0);
    chk("outputs in reset", 32'(outv()), 32'(mkv(0, 0, 0, 0, 2'b10, 1, 2'b10, 2'b01, 0, 3'b000, 0)));
    @(posedge clk);
    @(negedge clk);
    chk("MemWrite held in reset", 32'(bus.MemWrite), 32'd0);
    @(posedge clk); #1;
    reset  = 1'b1;
    mflags = '0;
    // ADDCS must now be suppressed because the carry was cleared by reset
    run_model(20'h22802, "post-reset ADDCS");
    run_model(20'hEA000, "post-reset B");

    // Random instruction stream against the reference model
    for (int n = 0; n < 300; n++) begin
      logic [19:0] ins;
      ins = 20'($urandom);
      if ($urandom_range(0, 1) == 0) ins[19:16] = 4'hE;
      if ($urandom_range(0, 2) == 0) ins[15:14] = 2'b00;
      if ($urandom_range(0, 3) == 0) ins[3:0]   = 4'hF;
      run_model(ins, "rand");
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
